coin_credit_fsm: RTL

Parametrised credit controller for the coffee-maker front end. Accepts single-cycle coin pulses from N debounced coin channels, accumulates a saturating-checked credit, and runs a vend handshake with the brewing logic. After a vend or a cancel, it returns the remaining credit one unit at a time through a change handshake. It sits between the button/coin debouncers and the brewer, and its credit output drives the seven-segment display.

---
 rtl/coin_credit_fsm.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/coin_credit_fsm.sv
// Coin credit controller: accumulates coin credit, runs the vend handshake with the brewer,
// then pays remaining credit back one unit per change_ack.
module coin_credit_fsm #(
  parameter int                           NUM_COINS   = 2,
  parameter int                           COIN_W      = 4,
  parameter logic [NUM_COINS*COIN_W-1:0]  COIN_VALUES = {4'd5, 4'd1},
  parameter int                           CREDIT_W    = 8,
  parameter int                           CREDIT_MAX  = 99
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_COINS-1:0] coin,
  input  logic                 cancel,
  input  logic                 select,
  input  logic [CREDIT_W-1:0]  price,
  input  logic                 vend_done,
  input  logic                 change_ack,
  output logic [CREDIT_W-1:0]  credit,
  output logic                 coin_reject,
  output logic                 short,
  output logic                 vend_req,
  output logic                 change_req,
  output logic                 busy,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_VEND   = 2'd2,
    S_CHANGE = 2'd3
  } state_e;

  localparam logic [CREDIT_W:0] CREDIT_MAX_EXT = (CREDIT_W+1)'(CREDIT_MAX);

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                coin_reject_q, coin_reject_d;
  logic                short_q, short_d;
  logic                vend_req_q, vend_req_d;
  logic                change_req_q, change_req_d;
  logic                busy_q, busy_d;

  logic                cand_hit;
  logic [COIN_W-1:0]   cand_val;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_fits;
  logic                coin_multi;
  logic                coin_any;
  logic                coin_en;

  // Lowest-index asserted channel is the only coin that can be credited.
  always_comb begin
    cand_hit = 1'b0;
    cand_val = '0;
    for (int i = NUM_COINS - 1; i >= 0; i--) begin
      if (coin[i]) begin
        cand_hit = 1'b1;
        cand_val = COIN_VALUES[i*COIN_W +: COIN_W];
      end
    end
  end

  assign coin_sum   = {1'b0, credit_q} + (CREDIT_W+1)'(cand_val);
  assign coin_fits  = cand_hit && (coin_sum <= CREDIT_MAX_EXT);
  assign coin_multi = |(coin & (coin - NUM_COINS'(1)));
  assign coin_any   = |coin;

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    coin_reject_d = 1'b0;
    short_d       = 1'b0;
    vend_req_d    = vend_req_q;
    change_req_d  = change_req_q;
    coin_en       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        short_d = select;
        coin_en = 1'b1;
      end
      S_ACCUM: begin
        if (cancel) begin
          state_d      = S_CHANGE;
          change_req_d = (credit_q != '0);
        end else if (select && (price != '0) && (credit_q >= price)) begin
          state_d    = S_VEND;
          credit_d   = credit_q - price;
          vend_req_d = 1'b1;
        end else begin
          // A refused select leaves the coin path free this cycle.
          short_d = select;
          coin_en = 1'b1;
        end
      end
      S_VEND: begin
        if (vend_done) begin
          vend_req_d = 1'b0;
          if (credit_q != '0) begin
            state_d      = S_CHANGE;
            change_req_d = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_CHANGE: begin
        if (change_ack && (credit_q != '0)) begin
          credit_d = credit_q - CREDIT_W'(1);
          if (credit_q == CREDIT_W'(1)) begin
            change_req_d = 1'b0;
            state_d      = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (coin_en && coin_fits) begin
      credit_d      = coin_sum[CREDIT_W-1:0];
      state_d       = S_ACCUM;
      coin_reject_d = coin_multi;
    end else begin
      coin_reject_d = coin_any;
    end

    busy_d = (state_d == S_VEND) || (state_d == S_CHANGE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      credit_q      <= '0;
      coin_reject_q <= 1'b0;
      short_q       <= 1'b0;
      vend_req_q    <= 1'b0;
      change_req_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      coin_reject_q <= coin_reject_d;
      short_q       <= short_d;
      vend_req_q    <= vend_req_d;
      change_req_q  <= change_req_d;
      busy_q        <= busy_d;
    end
  end

  assign credit      = credit_q;
  assign coin_reject = coin_reject_q;
  assign short       = short_q;
  assign vend_req    = vend_req_q;
  assign change_req  = change_req_q;
  assign busy        = busy_q;
  assign state_dbg   = state_q;

endmodule
